// File: rtl/adam_periph_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adam_periph_uart_pkg
// Brief   : Shared types and constants for the adam UART peripheral (RX/TX).
// Revision: 1.0 - initial release
// ============================================================================
package adam_periph_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int SHIFT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/adam_periph_uart_sync.sv
`default_nettype none
// ============================================================================
// Module  : adam_periph_uart_sync
// Brief   : Two-flop synchroniser for an asynchronous single-bit input.
// Revision: 1.0 - initial release
// ============================================================================
module adam_periph_uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/adam_periph_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : adam_periph_uart_rx
// Brief   : UART receiver with valid/ready word output and pause handshake.
// Revision: 1.0 - initial release
// ============================================================================
module adam_periph_uart_rx
    import adam_periph_uart_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter type data_t     = logic [DATA_WIDTH-1:0]
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_req,
    output logic        pause_ack,
    input  logic        parity_select,
    input  logic        parity_control,
    input  logic [3:0]  data_length,
    input  logic        stop_bits,
    input  data_t       baud_rate,
    output data_t       data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        parity_error,
    output logic        frame_error,
    output logic        overrun,
    input  logic        rx
);

    logic w_rx_s;
    logic rx_prev_q;

    rx_state_t               state_q, state_d;
    data_t                   clk_count_q, clk_count_d;
    logic [3:0]              bit_idx_q, bit_idx_d;
    logic [SHIFT_WIDTH-1:0]  shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    done_q, done_d;
    logic                    pause_ack_q, pause_ack_d;
    data_t                   data_q, data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    frame_error_q, frame_error_d;
    logic                    overrun_q, overrun_d;

    logic w_mid_bit;
    logic w_full_bit;
    logic unused_stop_bits;

    // The receiver only checks the first stop bit; extra stop time is idle line.
    assign unused_stop_bits = stop_bits;

    adam_periph_uart_sync #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (w_rx_s)
    );

    assign w_mid_bit  = (clk_count_q == (baud_rate >> 1));
    assign w_full_bit = (clk_count_q == baud_rate);

    always_comb begin
        state_d        = state_q;
        clk_count_d    = clk_count_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        par_d          = par_q;
        perr_d         = perr_q;
        ferr_d         = ferr_q;
        done_d         = 1'b0;
        pause_ack_d    = pause_ack_q;
        data_d         = data_q;
        data_valid_d   = data_valid_q;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
        overrun_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pause_req) begin
                    pause_ack_d = 1'b1;
                end else if (pause_ack_q) begin
                    pause_ack_d = 1'b0;
                end else if (rx_prev_q && !w_rx_s) begin
                    state_d     = START;
                    clk_count_d = '0;
                    bit_idx_d   = '0;
                    shift_d     = '0;
                    par_d       = 1'b0;
                    perr_d      = 1'b0;
                    ferr_d      = 1'b0;
                end
            end
            START: begin
                if (w_mid_bit) begin
                    clk_count_d = '0;
                    if (w_rx_s) begin
                        state_d = IDLE;
                    end else if (data_length == 4'd0) begin
                        state_d = parity_control ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    clk_count_d = clk_count_q + data_t'(1);
                end
            end
            DATA: begin
                if (w_full_bit) begin
                    clk_count_d        = '0;
                    shift_d[bit_idx_q] = w_rx_s;
                    par_d              = par_q ^ w_rx_s;
                    if (bit_idx_q == data_length - 4'd1) begin
                        state_d = parity_control ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + data_t'(1);
                end
            end
            PARITY: begin
                if (w_full_bit) begin
                    clk_count_d = '0;
                    perr_d      = w_rx_s ^ par_q ^ (parity_select == PARITY_ODD);
                    state_d     = STOP;
                end else begin
                    clk_count_d = clk_count_q + data_t'(1);
                end
            end
            STOP: begin
                if (w_full_bit) begin
                    clk_count_d = '0;
                    ferr_d      = !w_rx_s;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    clk_count_d = clk_count_q + data_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed frame only replaces the output word if the slot is free or draining.
        if (done_q) begin
            if (!data_valid_q || data_ready) begin
                data_d         = data_t'(shift_q);
                parity_error_d = perr_q;
                frame_error_d  = ferr_q;
                data_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q      <= 1'b1;
            state_q        <= IDLE;
            clk_count_q    <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            par_q          <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            done_q         <= 1'b0;
            pause_ack_q    <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            rx_prev_q      <= w_rx_s;
            state_q        <= state_d;
            clk_count_q    <= clk_count_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            done_q         <= done_d;
            pause_ack_q    <= pause_ack_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            overrun_q      <= overrun_d;
        end
    end

    assign pause_ack    = pause_ack_q;
    assign data         = data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adam_periph_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_adam_periph_uart_rx
// Brief   : Self-checking bench for adam_periph_uart_rx with a word-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adam_periph_uart_rx;

    localparam int BIT_CYC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pause_req = 1'b0;
    logic        pause_ack;
    logic        parity_select = 1'b0;
    logic        parity_control = 1'b0;
    logic [3:0]  data_length = 4'd8;
    logic        stop_bits = 1'b0;
    logic [31:0] baud_rate = 32'd9;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready = 1'b0;
    logic        parity_error;
    logic        frame_error;
    logic        overrun;
    logic        rx = 1'b1;

    always #5 clk = ~clk;

    adam_periph_uart_rx #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pause_req      (pause_req),
        .pause_ack      (pause_ack),
        .parity_select  (parity_select),
        .parity_control (parity_control),
        .data_length    (data_length),
        .stop_bits      (stop_bits),
        .baud_rate      (baud_rate),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .overrun        (overrun),
        .rx             (rx)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        pe;
        logic        fe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ov   = 0;
    int   ov_hi    = 0;
    int   ov_rise  = 0;
    logic ov_prev  = 1'b0;
    logic in_frame = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level scoreboard: whatever is presented must be the oldest undelivered word.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_frame) chk("pause_ack_mid_frame", {31'd0, pause_ack}, 32'd0);
            if (data_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: data=0x%0h with no word expected", data);
                end else begin
                    chk("sb_data", data, q[0].d);
                    chk("sb_parity_error", {31'd0, parity_error}, {31'd0, q[0].pe});
                    chk("sb_frame_error", {31'd0, frame_error}, {31'd0, q[0].fe});
                    if (data_ready) void'(q.pop_front());
                end
            end
            if (overrun) ov_hi++;
            if (overrun && !ov_prev) ov_rise++;
            ov_prev = overrun;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(BIT_CYC);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!data_valid && k < 500) begin
            tick(1);
            k++;
        end
        chk(name, {31'd0, data_valid}, 32'd1);
    endtask

    task automatic wait_ack(input logic v);
        int k = 0;
        while (pause_ack !== v && k < 300) begin
            tick(1);
            k++;
        end
        chk("pause_ack_wait", {31'd0, pause_ack}, {31'd0, v});
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic pen, input logic psel, input logic st2);
        pause_req = 1'b1;
        wait_ack(1'b1);
        data_length    = len;
        parity_control = pen;
        parity_select  = psel;
        stop_bits      = st2;
        tick(2);
        pause_req = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic handshake();
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
        @(negedge clk);
        chk("valid_falls_after_transfer", {31'd0, data_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Drives one frame with the current config and predicts its effect on the output slot.
    task automatic send_frame(input logic [15:0] w, input logic flip_par, input logic bad_stop);
        logic [31:0] d;
        logic        pbit;
        exp_t        e;
        d    = {16'd0, w} & ((32'd1 << data_length) - 32'd1);
        pbit = ($countones(d) % 2 == 1) ^ (parity_select == 1'b1) ^ flip_par;
        e.d  = d;
        e.pe = parity_control ? ((($countones(d) + int'(pbit)) % 2) != int'(parity_select)) : 1'b0;
        e.fe = bad_stop;
        in_frame = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < int'(data_length); i++) drive_bit(w[i]);
        if (parity_control) drive_bit(pbit);
        in_frame = 1'b0;
        if (!data_ready && q.size() > 0) exp_ov++;
        else q.push_back(e);
        drive_bit(!bad_stop);
        if (stop_bits) drive_bit(1'b1);
        rx = 1'b1;
        tick(BIT_CYC);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_before;
        tick(4);
        chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_data", data, 32'd0);
        chk("reset_pause_ack", {31'd0, pause_ack}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        tick(20);

        // 8N1 0xA5
        send_frame(16'h00A5, 1'b0, 1'b0);
        wait_valid("8n1_valid");
        chk("8n1_data", data, 32'h0000_00A5);
        chk("8n1_perr", {31'd0, parity_error}, 32'd0);
        chk("8n1_ferr", {31'd0, frame_error}, 32'd0);
        tick(5);
        chk("8n1_valid_held", {31'd0, data_valid}, 32'd1);
        handshake();

        // 7E1 0x41, then with the parity bit flipped
        set_cfg(4'd7, 1'b1, 1'b0, 1'b0);
        send_frame(16'h0041, 1'b0, 1'b0);
        wait_valid("7e1_valid");
        chk("7e1_data", data, 32'h41);
        chk("7e1_perr", {31'd0, parity_error}, 32'd0);
        handshake();
        send_frame(16'h0041, 1'b1, 1'b0);
        wait_valid("7e1_bad_valid");
        chk("7e1_bad_perr", {31'd0, parity_error}, 32'd1);
        handshake();

        // 8O2 with a bad stop bit, then a clean frame
        set_cfg(4'd8, 1'b1, 1'b1, 1'b1);
        send_frame(16'h0000, 1'b0, 1'b1);
        wait_valid("8o2_valid");
        chk("8o2_ferr", {31'd0, frame_error}, 32'd1);
        chk("8o2_data", data, 32'd0);
        handshake();
        send_frame(16'h003C, 1'b0, 1'b0);
        wait_valid("8o2_resync_valid");
        chk("8o2_resync_data", data, 32'h3C);
        chk("8o2_resync_ferr", {31'd0, frame_error}, 32'd0);
        chk("8o2_resync_perr", {31'd0, parity_error}, 32'd0);
        handshake();

        // Short low glitch must not produce a word
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        chk("glitch_no_valid", {31'd0, data_valid}, 32'd0);
        send_frame(16'h005A, 1'b0, 1'b0);
        wait_valid("after_glitch_valid");
        chk("after_glitch_data", data, 32'h5A);
        handshake();

        // Overrun: second word dropped, first retained
        ov_before = ov_hi;
        send_frame(16'h0011, 1'b0, 1'b0);
        send_frame(16'h0022, 1'b0, 1'b0);
        tick(5);
        chk("overrun_once", ov_hi - ov_before, 32'd1);
        chk("overrun_kept_data", data, 32'h11);
        handshake();
        tick(3);
        chk("overrun_dropped", q.size(), 32'd0);

        // Pause requested mid-frame, granted only once the frame is done
        fork
            send_frame(16'h00C3, 1'b0, 1'b0);
            begin
                tick(30);
                pause_req = 1'b1;
            end
        join
        wait_ack(1'b1);
        chk("pause_held_word", data, 32'hC3);
        handshake();
        data_length = 4'd5;
        tick(2);
        pause_req = 1'b0;
        wait_ack(1'b0);
        send_frame(16'h001F, 1'b0, 1'b0);
        wait_valid("5bit_valid");
        chk("5bit_data", data, 32'h1F);
        handshake();

        // Randomised frames, configs and consumer behaviour
        for (int n = 0; n < 30; n++) begin
            logic pen;
            if ($urandom_range(0, 2) == 0) begin
                pen = 1'($urandom_range(0, 1));
                set_cfg(4'($urandom_range(0, 15)), pen, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            end
            data_ready = 1'($urandom_range(0, 1));
            send_frame(16'($urandom), parity_control && ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0));
            tick($urandom_range(1, 25));
        end

        // Reset mid-frame discards the pending word
        data_ready = 1'b1;
        tick(3);
        data_ready = 1'b0;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        send_frame(16'h0077, 1'b0, 1'b0);
        rx = 1'b0;
        tick(35);
        rst = 1'b1;
        tick(2);
        q.delete();
        rx = 1'b1;
        chk("midreset_valid", {31'd0, data_valid}, 32'd0);
        chk("midreset_data", data, 32'd0);
        rst = 1'b0;
        tick(20);
        send_frame(16'h0099, 1'b0, 1'b0);
        wait_valid("post_reset_valid");
        chk("post_reset_data", data, 32'h99);
        handshake();

        chk("overrun_cycles", ov_hi, exp_ov);
        chk("overrun_pulses", ov_rise, exp_ov);
        data_ready = 1'b1;
        tick(5);
        chk("final_queue_empty", q.size(), 32'd0);
        chk("final_valid", {31'd0, data_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
